ram_responder: RTL and testbench
================================

// Module: ram_responder
// PURPOSE
//  Memory-side end of the RAM controller interface: consumes the controller's registered
//  RAMaddr/toRAM/w outputs and serves them from an on-chip word array.
//  Adds a read path (rd -> rdata/rvalid) and a whole-array clear engine.
//  Sits between the RAM controller and the CPU register write-back/load path.
// PARAMETERS
//  ADDR_W        12  implemented address bits; array depth = 2**ADDR_W 16-bit words
//  CLEAR_ON_RST  1   1: start a clear pass automatically when reset deasserts
// PORTS
//  clk      in   1   system clock, all state on rising edge
//  rst      in   1   asynchronous, active-low reset
//  RAMaddr  in   16  word address from RAM controller
//  toRAM    in   16  write data from RAM controller
//  w        in   1   write strobe, one word per cycle it is high
//  rd       in   1   read request, address taken from RAMaddr this cycle
//  clr      in   1   pulse: start clear pass (zero every word)
//  rdata    out  16  read data, valid while rvalid=1
//  rvalid   out  1   one-cycle pulse, read result available
//  busy     out  1   clear pass in progress, requests refused
//  err      out  1   one-cycle pulse: out-of-range access or request refused while busy
// BEHAVIOUR
//  Reset (rst=0): rdata=0, rvalid=0, err=0, clear counter=0; busy=CLEAR_ON_RST
//   (state=CLEAR if CLEAR_ON_RST else IDLE). Array contents not reset.
//  Range: access in range iff RAMaddr[15:ADDR_W]==0. Index = RAMaddr[ADDR_W-1:0].
//  FSM states IDLE, CLEAR.
//   IDLE: w=1, in range -> mem[idx]<=toRAM at this edge.
//         rd=1, in range -> next cycle rvalid=1, rdata=mem[idx].
//         rd=1, out of range -> next cycle rvalid=1, rdata=0, err=1.
//         w=1, out of range -> write dropped, next cycle err=1.
//         w & rd same cycle, same idx -> write-first: rdata=toRAM.
//         clr=1 -> CLEAR, counter<=0, busy<=1 next cycle. clr has priority:
//           w/rd in the clr cycle still served normally.
//   CLEAR: each cycle mem[counter]<=0, counter<=counter+1.
//         counter==2**ADDR_W-1 -> write last word, go IDLE, busy<=0 next cycle.
//         Pass length exactly 2**ADDR_W cycles.
//         rd or w during CLEAR -> not performed; next cycle err=1, rvalid stays 0.
//         clr during CLEAR ignored; no restart.
//  Read latency fixed 1 cycle; back-to-back rd every cycle supported.
//  rdata holds its last value when rvalid=0.
//  err and rvalid are registered; they never assert in the cycle of the request.
//  Reset mid-clear aborts immediately. Words not yet cleared keep their old contents.
//   Restarts from 0 after reset only if CLEAR_ON_RST=1.
//  Counter width ADDR_W, wraps only at pass end.
// STRUCTURE
//  Shared pkg/include: state encodings ST_IDLE=1'b0, ST_CLEAR=1'b1; DATA_W=16.
//  One sub-module: ram_array. Synchronous 1R1W, registered read, write-first bypass.
//  This block holds the FSM, clear counter, range check and err/rvalid registers.
// TESTING
//  1 CLEAR_ON_RST=1: release rst -> busy=1 for 4096 cycles, then 0.
//    rd 0x0FFF -> rvalid next cycle, rdata=0x0000.
//  2 w@0x0010 data 0xBEEF; next cycle rd 0x0010 -> rvalid=1, rdata=0xBEEF, err=0.
//  3 Same cycle w=1,rd=1 @0x0020 data 0x1234 -> next cycle rdata=0x1234.
//    Following read returns 0x1234.
//  4 rd 0x1000 -> rvalid=1, rdata=0, err=1.
//    w 0xF000 data 0x5555 -> err=1; rd 0x0000 returns unchanged value.
//  5 clr pulse, then rd 0x0010 while busy -> err=1, no rvalid.
//    After busy falls, rd 0x0010 -> 0x0000.
//  6 rst low at clear cycle 100, data 0xAAAA preloaded everywhere (CLEAR_ON_RST=0).
//    -> outputs at reset values, busy=0. 0x0005 reads 0, 0x0200 reads 0xAAAA.

Source files
------------

// File: rtl/ram_responder_pkg.sv
// Shared types and widths for the RAM responder and its storage array.
package ram_responder_pkg;

  localparam int DATA_W = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/ram_responder_array.sv
// Synchronous 1R1W word array with registered read port and write-first bypass.
// The read register can also be loaded with zero (used for refused out-of-range reads).
module ram_array
  import ram_responder_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic              rz,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Storage is deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (rz) begin
      q <= '0;
    end else if (re) begin
      q <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/ram_responder.sv
// Memory-side responder for the RAM controller: range check, read/write service,
// whole-array clear engine and registered rvalid/err/busy status.
//
// state    | meaning
// ST_IDLE  | serving w/rd requests, clr starts a clear pass
// ST_CLEAR | zeroing one word per cycle, requests refused with err
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       RAMaddr,
  input  logic [15:0]       toRAM,
  input  logic              w,
  input  logic              rd,
  input  logic              clr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              in_range;
  logic [ADDR_W-1:0] idx;
  logic              clearing;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata;
  logic              arr_re;
  logic              arr_rz;

  assign in_range  = (RAMaddr[15:ADDR_W] == '0);
  assign idx       = RAMaddr[ADDR_W-1:0];
  assign clearing  = (state == ST_CLEAR);

  // The clear engine owns the write port for the whole pass.
  assign arr_we    = clearing | (w & in_range);
  assign arr_waddr = clearing ? cnt : idx;
  assign arr_wdata = clearing ? '0 : toRAM;
  assign arr_re    = ~clearing & rd & in_range;
  assign arr_rz    = ~clearing & rd & ~in_range;

  ram_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .re    (arr_re),
    .rz    (arr_rz),
    .raddr (idx),
    .q     (rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= CLEAR_ON_RST ? ST_CLEAR : ST_IDLE;
      cnt    <= '0;
      busy   <= CLEAR_ON_RST;
      rvalid <= 1'b0;
      err    <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          rvalid <= rd;
          err    <= (rd | w) & ~in_range;
          if (clr) begin
            state <= ST_CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          err <= rd | w;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: instance 0 clears on reset, instance 1 does not.
`timescale 1ns/1ps
module tb_ram_responder;

  typedef struct {
    int          inst;
    int          cyc;
    logic        rvalid;
    logic [15:0] rdata;
    logic        err;
    string       name;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_s    [2];
  logic [15:0] addr_s   [2];
  logic [15:0] wd_s     [2];
  logic        w_s      [2];
  logic        rd_s     [2];
  logic        clr_s    [2];
  logic [15:0] rdata_s  [2];
  logic        rvalid_s [2];
  logic        busy_s   [2];
  logic        err_s    [2];

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [15:0] last_rd [2];
  resp_t       q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_responder #(.ADDR_W(12), .CLEAR_ON_RST(1'b1)) u_dut0 (
    .clk(clk), .rst(rst_s[0]), .RAMaddr(addr_s[0]), .toRAM(wd_s[0]), .w(w_s[0]),
    .rd(rd_s[0]), .clr(clr_s[0]), .rdata(rdata_s[0]), .rvalid(rvalid_s[0]),
    .busy(busy_s[0]), .err(err_s[0]));

  ram_responder #(.ADDR_W(12), .CLEAR_ON_RST(1'b0)) u_dut1 (
    .clk(clk), .rst(rst_s[1]), .RAMaddr(addr_s[1]), .toRAM(wd_s[1]), .w(w_s[1]),
    .rd(rd_s[1]), .clr(clr_s[1]), .rdata(rdata_s[1]), .rvalid(rvalid_s[1]),
    .busy(busy_s[1]), .err(err_s[1]));

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic int find(int k);
    for (int i = 0; i < q.size(); i++) if (q[i].inst == k) return i;
    return -1;
  endfunction

  task automatic exp_resp(int k, logic rv, logic [15:0] rdv, logic er, string nm);
    resp_t e;
    if (rv) last_rd[k] = rdv;
    e.inst = k; e.cyc = cyc + 1; e.rvalid = rv; e.rdata = last_rd[k];
    e.err = er; e.name = nm;
    q.push_back(e);
  endtask

  task automatic step(int k, logic wv, logic rv, logic cv, logic [15:0] a, logic [15:0] d);
    w_s[k] = wv; rd_s[k] = rv; clr_s[k] = cv; addr_s[k] = a; wd_s[k] = d;
    @(posedge clk); #1;
  endtask

  task automatic mon(int k);
    int    i;
    resp_t e;
    i = find(k);
    if (i >= 0 && q[i].cyc < cyc) begin
      checks++; failures++;
      $display("FAIL %s no response: actual=none required=cycle %0d", q[i].name, q[i].cyc);
      q.delete(i);
      i = find(k);
    end
    if (rvalid_s[k] || err_s[k]) begin
      if (i < 0) begin
        checks++; failures++;
        $display("FAIL unexpected_resp inst=%0d actual rvalid=%0b err=%0b rdata=0x%0h required=none",
                 k, rvalid_s[k], err_s[k], rdata_s[k]);
      end else begin
        e = q[i];
        q.delete(i);
        chk({e.name, "_cycle"},  cyc,         e.cyc);
        chk({e.name, "_rvalid"}, rvalid_s[k], e.rvalid);
        chk({e.name, "_rdata"},  rdata_s[k],  e.rdata);
        chk({e.name, "_err"},    err_s[k],    e.err);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) mon(k);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int k = 0; k < 2; k++) begin
      rst_s[k] = 1'b0; addr_s[k] = '0; wd_s[k] = '0;
      w_s[k] = 1'b0; rd_s[k] = 1'b0; clr_s[k] = 1'b0; last_rd[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst0_rdata", rdata_s[0], 16'h0000);
    chk("rst0_rvalid", rvalid_s[0], 1'b0);
    chk("rst0_err", err_s[0], 1'b0);
    chk("rst0_busy", busy_s[0], 1'b1);
    chk("rst1_busy", busy_s[1], 1'b0);

    // 1: automatic clear pass after reset
    rst_s[0] = 1'b1;
    n = 0;
    while (busy_s[0] && n < 5000) begin
      @(posedge clk); #1; n++;
    end
    chk("t1_busy_len", n, 4096);
    exp_resp(0, 1'b1, 16'h0000, 1'b0, "t1_rd_0fff");
    step(0, 1'b0, 1'b1, 1'b0, 16'h0FFF, 16'h0);

    // 2: write then read
    step(0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF);
    exp_resp(0, 1'b1, 16'hBEEF, 1'b0, "t2_rd_0010");
    step(0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);

    // 3: same-cycle write/read bypass, then plain readback
    exp_resp(0, 1'b1, 16'h1234, 1'b0, "t3_bypass");
    step(0, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h1234);
    exp_resp(0, 1'b1, 16'h1234, 1'b0, "t3_readback");
    step(0, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h0);

    // back-to-back reads every cycle
    exp_resp(0, 1'b1, 16'hBEEF, 1'b0, "b2b_0010");
    step(0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
    exp_resp(0, 1'b1, 16'h1234, 1'b0, "b2b_0020");
    step(0, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h0);
    exp_resp(0, 1'b1, 16'h0000, 1'b0, "b2b_0fff");
    step(0, 1'b0, 1'b1, 1'b0, 16'h0FFF, 16'h0);
    exp_resp(0, 1'b1, 16'hBEEF, 1'b0, "b2b_0010b");
    step(0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
    step(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("hold_rdata", rdata_s[0], 16'hBEEF);

    // 4: out-of-range read and write
    exp_resp(0, 1'b1, 16'h0000, 1'b1, "t4_rd_1000");
    step(0, 1'b0, 1'b1, 1'b0, 16'h1000, 16'h0);
    exp_resp(0, 1'b0, 16'h0, 1'b1, "t4_wr_f000");
    step(0, 1'b1, 1'b0, 1'b0, 16'hF000, 16'h5555);
    exp_resp(0, 1'b1, 16'h0000, 1'b0, "t4_rd_0000");
    step(0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0);

    // 5: clr with a read in the same cycle, then refused requests during the pass
    exp_resp(0, 1'b1, 16'h1234, 1'b0, "t5_clr_rd");
    step(0, 1'b0, 1'b1, 1'b1, 16'h0020, 16'h0);
    chk("t5_busy_set", busy_s[0], 1'b1);
    exp_resp(0, 1'b0, 16'h0, 1'b1, "t5_rd_busy");
    step(0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
    exp_resp(0, 1'b0, 16'h0, 1'b1, "t5_wr_busy");
    step(0, 1'b1, 1'b0, 1'b0, 16'h0030, 16'h9999);
    step(0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    step(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    n = 4;
    while (busy_s[0] && n < 5000) begin
      @(posedge clk); #1; n++;
    end
    chk("t5_busy_len", n, 4096);
    exp_resp(0, 1'b1, 16'h0000, 1'b0, "t5_rd_0010");
    step(0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
    exp_resp(0, 1'b1, 16'h0000, 1'b0, "t5_rd_0020");
    step(0, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h0);
    step(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

    // 6: reset mid-clear on the instance without clear-on-reset
    rst_s[1] = 1'b1;
    step(1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 4096; i++) step(1, 1'b1, 1'b0, 1'b0, 16'(i), 16'hAAAA);
    exp_resp(1, 1'b1, 16'hAAAA, 1'b0, "t6_preload_rd");
    step(1, 1'b0, 1'b1, 1'b0, 16'h0300, 16'h0);
    step(1, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    clr_s[1] = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    rd_s[1] = 1'b1; addr_s[1] = 16'h0010;
    @(posedge clk); #1;
    rst_s[1] = 1'b0; rd_s[1] = 1'b0;
    #1;
    chk("t6_rst_rdata", rdata_s[1], 16'h0000);
    chk("t6_rst_rvalid", rvalid_s[1], 1'b0);
    chk("t6_rst_err", err_s[1], 1'b0);
    chk("t6_rst_busy", busy_s[1], 1'b0);
    last_rd[1] = 16'h0000;
    @(posedge clk); #1;
    rst_s[1] = 1'b1;
    step(1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("t6_busy_after", busy_s[1], 1'b0);
    exp_resp(1, 1'b1, 16'h0000, 1'b0, "t6_rd_0005");
    step(1, 1'b0, 1'b1, 1'b0, 16'h0005, 16'h0);
    exp_resp(1, 1'b1, 16'h0000, 1'b0, "t6_rd_0063");
    step(1, 1'b0, 1'b1, 1'b0, 16'h0063, 16'h0);
    exp_resp(1, 1'b1, 16'hAAAA, 1'b0, "t6_rd_0064");
    step(1, 1'b0, 1'b1, 1'b0, 16'h0064, 16'h0);
    exp_resp(1, 1'b1, 16'hAAAA, 1'b0, "t6_rd_0200");
    step(1, 1'b0, 1'b1, 1'b0, 16'h0200, 16'h0);
    exp_resp(1, 1'b1, 16'hAAAA, 1'b0, "t6_rd_0fff");
    step(1, 1'b0, 1'b1, 1'b0, 16'h0FFF, 16'h0);
    step(1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
